// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Purpose
//   Fetches instructions from the ICache ahead of the decoder and keeps them in
//   an IQ_DEPTH-entry FIFO of {pc, inst, predict}. The decoder can then pop one
//   instruction per cycle without waiting on the ICache. The fetch pc is
//   redirected at fetch time for jal and predicted branches. A jalr stalls
//   fetch until the RoB supplies the target. A mispredict flushes the queue and
//   drops the ICache response that is still in flight. Predictor queries and
//   branch-resolution feedback are also generated here.
//
// Ports
//   Sys_clk, Sys_rst       clock, synchronous active-high reset
//   Sys_rdy                global enable; when 0 every register holds and
//                          no ICache request is issued
//   IFIC_en / IFIC_addr    ICache request (combinational) and address (= fpc)
//   ICIF_en / ICIF_data    ICache response valid / instruction
//   IFPD_predict_en/_pc    predictor query for a branch being pushed
//   PDIF_predict_result    same-cycle prediction (1 = taken)
//   IFPD_feedback_*        registered copy of the RoB branch resolution
//   IFDC_*                 queue head towards the decoder
//   DCIF_ask_IF            decoder pops the head this cycle
//   RoBIF_*                jalr target, branch resolution, redirect target
//   IF_count               number of occupied queue entries
//   dbg_state              current FSM state (FETCH=0, WAIT_IC=1, WAIT_JALR=2)
//
// Handshakes
//   Decoder side: an entry moves when IFDC_en and DCIF_ask_IF are both high in
//   the same cycle. DCIF_ask_IF has no effect while the queue is empty.
//   ICache side: IFIC_en is a one-cycle request. The ICache answers later with
//   a one-cycle ICIF_en. At most one request is outstanding at any time.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    IQ_DEPTH_LOG = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,
    output logic                    IFIC_en,
    output logic [ADDR_WIDTH-1:0]   IFIC_addr,
    input  logic                    ICIF_en,
    input  logic [31:0]             ICIF_data,
    output logic                    IFPD_predict_en,
    output logic [ADDR_WIDTH-1:0]   IFPD_pc,
    input  logic                    PDIF_predict_result,
    output logic                    IFPD_feedback_en,
    output logic [ADDR_WIDTH-1:0]   IFPD_feedback_pc,
    output logic                    IFPD_branch_result,
    output logic                    IFDC_en,
    output logic [ADDR_WIDTH-1:0]   IFDC_pc,
    output logic [31:0]             IFDC_inst,
    output logic                    IFDC_predict_result,
    input  logic                    DCIF_ask_IF,
    input  logic                    RoBIF_jalr_en,
    input  logic                    RoBIF_branch_en,
    input  logic                    RoBIF_pre_judge,
    input  logic                    RoBIF_branch_result,
    input  logic [ADDR_WIDTH-1:0]   RoBIF_branch_pc,
    input  logic [ADDR_WIDTH-1:0]   RoBIF_next_pc,
    output logic [IQ_DEPTH_LOG:0]   IF_count,
    output logic [1:0]              dbg_state
);

    localparam int IQ_DEPTH = 1 << IQ_DEPTH_LOG;
    localparam logic [IQ_DEPTH_LOG:0] FULL_COUNT = (IQ_DEPTH_LOG + 1)'(IQ_DEPTH);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        WAIT_IC   = 2'd1,
        WAIT_JALR = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   state, state_n;
    logic [ADDR_WIDTH-1:0]    fpc, fpc_n;
    logic                     stale, stale_n;
    logic [IQ_DEPTH_LOG-1:0]  head, tail;
    logic [IQ_DEPTH_LOG:0]    count, count_n;
    logic                     fb_en;
    logic [ADDR_WIDTH-1:0]    fb_pc;
    logic                     fb_result;

    logic [ADDR_WIDTH-1:0]    q_pc   [IQ_DEPTH];
    logic [31:0]              q_inst [IQ_DEPTH];
    logic                     q_pred [IQ_DEPTH];

    // ------------------------------------------------------------------
    // Decode of the incoming response
    // ------------------------------------------------------------------
    logic                  mispredict;
    logic                  ic_req;
    logic                  resp_live;
    logic                  is_branch;
    logic                  entry_pred;
    logic                  push;
    logic                  pop;
    logic                  head_valid;
    logic [6:0]            opcode;
    logic [ADDR_WIDTH-1:0] imm_j;
    logic [ADDR_WIDTH-1:0] imm_b;
    logic [ADDR_WIDTH-1:0] fpc_plus4;

    assign mispredict = RoBIF_branch_en & ~RoBIF_pre_judge;
    assign head_valid = (count != '0);
    assign opcode     = ICIF_data[6:0];

    // Immediates are sign-extended across the whole pc width. The pc sums
    // below then wrap modulo 2^ADDR_WIDTH.
    assign imm_j = {{(ADDR_WIDTH-20){ICIF_data[31]}}, ICIF_data[19:12], ICIF_data[20],
                    ICIF_data[30:21], 1'b0};
    assign imm_b = {{(ADDR_WIDTH-12){ICIF_data[31]}}, ICIF_data[7], ICIF_data[30:25],
                    ICIF_data[11:8], 1'b0};
    assign fpc_plus4 = fpc + ADDR_WIDTH'(4);

    // Only issue a request when the queue has room for the answer. This
    // guarantees that a push can never hit a full queue.
    assign ic_req = Sys_rdy & ~Sys_rst & (state == FETCH) & (count != FULL_COUNT) & ~mispredict;

    // A response is live only when the FSM is waiting for it. A response
    // that belongs to a flushed request (stale) is consumed but not pushed.
    assign resp_live  = Sys_rdy & ~Sys_rst & (state == WAIT_IC) & ICIF_en & ~stale;
    assign is_branch  = resp_live & (opcode == OP_BRANCH);
    assign entry_pred = is_branch & PDIF_predict_result;

    assign push = resp_live & ~mispredict;
    assign pop  = Sys_rdy & DCIF_ask_IF & head_valid & ~mispredict;

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        fpc_n   = fpc;
        stale_n = stale;
        if (mispredict) begin
            fpc_n = RoBIF_next_pc;
            if (state == WAIT_IC && !ICIF_en) begin
                // The outstanding answer will still arrive. Mark it so it
                // gets dropped instead of pushed.
                state_n = WAIT_IC;
                stale_n = 1'b1;
            end else begin
                state_n = FETCH;
                stale_n = 1'b0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (ic_req) begin
                        state_n = WAIT_IC;
                    end
                end
                WAIT_IC: begin
                    if (ICIF_en) begin
                        state_n = FETCH;
                        if (stale) begin
                            // fpc was already redirected by the mispredict.
                            stale_n = 1'b0;
                        end else begin
                            case (opcode)
                                OP_JAL:    fpc_n = fpc + imm_j;
                                OP_BRANCH: fpc_n = PDIF_predict_result ? (fpc + imm_b) : fpc_plus4;
                                OP_JALR:   state_n = WAIT_JALR;
                                default:   fpc_n = fpc_plus4;
                            endcase
                        end
                    end
                end
                WAIT_JALR: begin
                    if (RoBIF_jalr_en) begin
                        fpc_n   = RoBIF_next_pc;
                        state_n = FETCH;
                    end
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            state     <= FETCH;
            fpc       <= RESET_PC;
            stale     <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            fb_en     <= 1'b0;
            fb_pc     <= '0;
            fb_result <= 1'b0;
        end else if (Sys_rdy) begin
            state     <= state_n;
            fpc       <= fpc_n;
            stale     <= stale_n;
            fb_en     <= RoBIF_branch_en;
            fb_pc     <= RoBIF_branch_pc;
            fb_result <= RoBIF_branch_result;
            if (mispredict) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                count <= count_n;
            end
        end
    end

    // The queue payload is not reset. The head outputs are masked while the
    // queue is empty.
    always_ff @(posedge Sys_clk) begin
        if (push) begin
            q_pc[tail]   <= fpc;
            q_inst[tail] <= ICIF_data;
            q_pred[tail] <= entry_pred;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign IFIC_en             = ic_req;
    assign IFIC_addr           = fpc;
    assign IFPD_predict_en     = is_branch;
    assign IFPD_pc             = fpc;
    assign IFPD_feedback_en    = fb_en;
    assign IFPD_feedback_pc    = fb_pc;
    assign IFPD_branch_result  = fb_result;
    assign IFDC_en             = head_valid;
    assign IFDC_pc             = head_valid ? q_pc[head]   : '0;
    assign IFDC_inst           = head_valid ? q_inst[head] : '0;
    assign IFDC_predict_result = head_valid ? q_pred[head] : 1'b0;
    assign IF_count            = count;
    assign dbg_state           = state;

endmodule
